// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / auto-reload expiry and cascade enable.
// Optional tick prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             TC_PULSE,
    output logic             BUSY
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] p_q, p_d;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) p_q <= '0;
        else        p_q <= p_d;
    end

    // Prescaler only advances on cycles that would otherwise count.
    always_comb begin
        p_d  = p_q;
        tick = 1'b0;
        if (!LOAD_n || STOP || (START && state_q == IDLE)) begin
            p_d = '0;
        end else if (state_q == RUN && ENT) begin
            tick = (p_q == PMAX);
            p_d  = tick ? '0 : p_q + 1'b1;
        end
    end
`else
    assign tick = (state_q == RUN) && ENT;
`endif

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Load beats stop, stop beats start, start beats counting.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (!LOAD_n) begin
            q_d      = D;
            reload_d = D;
        end else if (STOP) begin
            state_d = IDLE;
        end else if (START && state_q == IDLE) begin
            state_d = RUN;
        end else if (tick) begin
            if (q_q != '0) begin
                q_d = q_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                if (MODE) q_d     = reload_q;
                else      state_d = IDLE;
            end
        end
    end

    assign Q        = q_q;
    assign BO       = (q_q == '0) && ENT;
    assign TC_PULSE = tc_q;
    assign BUSY     = (state_q == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Directed plus randomized bench for down_timer against a cycle-level reference model.
module tb_down_timer;
    localparam int W = 8;
`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         CLK = 1'b0;
    logic         CLR_n = 1'b0;
    logic [W-1:0] D = '0;
    logic         LOAD_n = 1'b1;
    logic         START = 1'b0;
    logic         STOP = 1'b0;
    logic         MODE = 1'b0;
    logic         ENT = 1'b0;
    logic [W-1:0] Q;
    logic         BO, TC_PULSE, BUSY;

    int tests = 0;
    int fails = 0;

    // Reference state: plain integers and flags, updated once per edge.
    int m_q = 0, m_rl = 0, m_p = 0;
    bit m_run = 1'b0, m_tc = 1'b0;

    down_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n), .START(START),
        .STOP(STOP), .MODE(MODE), .ENT(ENT), .Q(Q), .BO(BO),
        .TC_PULSE(TC_PULSE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"}, 32'(Q), 32'(m_q));
        chk({tag, ".BUSY"}, 32'(BUSY), 32'(m_run));
        chk({tag, ".TC"}, 32'(TC_PULSE), 32'(m_tc));
        chk({tag, ".BO"}, 32'(BO), 32'((m_q == 0) && ENT));
    endtask

    task automatic model_reset;
        m_q = 0; m_rl = 0; m_p = 0; m_run = 1'b0; m_tc = 1'b0;
    endtask

    // Next-state of the model from the inputs present at the coming edge.
    task automatic model_step;
        bit t;
        t = 1'b0;
        m_tc = 1'b0;
        if (!LOAD_n) begin
            m_q = int'(D); m_rl = int'(D); m_p = 0;
        end else if (STOP) begin
            m_run = 1'b0; m_p = 0;
        end else if (START && !m_run) begin
            m_run = 1'b1; m_p = 0;
        end else if (m_run && ENT) begin
            if (m_p == PS - 1) begin
                m_p = 0; t = 1'b1;
            end else begin
                m_p = m_p + 1;
            end
        end
        if (t) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
                m_tc = 1'b1;
                if (MODE) m_q = m_rl;
                else      m_run = 1'b0;
            end
        end
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit ld_n, input bit st, input bit sp, input bit md,
                         input bit en, input logic [W-1:0] d);
        LOAD_n = ld_n; START = st; STOP = sp; MODE = md; ENT = en; D = d;
    endtask

    initial begin
        int tc_seen;
        #3;
        check_all("reset");
        chk("reset.Q0", 32'(Q), 0);
        #9 CLR_n = 1'b1;
        @(posedge CLK); #1;
        check_all("post_reset");

        // One-shot count from 3.
        drive(0, 0, 0, 0, 1, 8'd3); cyc("r036_load");
        chk("r036_loadQ", 32'(Q), 3);
        drive(1, 1, 0, 0, 1, 8'd0); cyc("r036_start");
        drive(1, 0, 0, 0, 1, 8'd0);
        tc_seen = 0;
        for (int i = 0; i < 4 * PS + 2; i++) begin
            cyc("r036_run");
            if (TC_PULSE) tc_seen++;
        end
        chk("r036_tc_count", 32'(tc_seen), 1);
        chk("r036_idle", 32'(BUSY), 0);
        chk("r036_q0", 32'(Q), 0);

        // Auto-reload from 2.
        drive(0, 0, 0, 1, 1, 8'd2); cyc("r037_load");
        drive(1, 1, 0, 1, 1, 8'd0); cyc("r037_start");
        drive(1, 0, 0, 1, 1, 8'd0);
        tc_seen = 0;
        for (int i = 0; i < 6 * PS; i++) begin
            cyc("r037_run");
            if (TC_PULSE) tc_seen++;
        end
        chk("r037_tc_count", 32'(tc_seen), 2);
        chk("r037_busy", 32'(BUSY), 1);

        // Freeze with ENT low at 5, then BO at zero.
        drive(0, 0, 1, 0, 0, 8'd5); cyc("r038_load");
        drive(1, 1, 0, 0, 0, 8'd0); cyc("r038_start");
        drive(1, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) cyc("r038_hold");
        chk("r038_q5", 32'(Q), 5);
        chk("r038_bo0", 32'(BO), 0);
        drive(1, 0, 0, 0, 1, 8'd0);
        for (int i = 0; i < 5 * PS; i++) cyc("r038_cnt");
        chk("r038_bo1", 32'(BO), 1);

        // Priority: load wins over stop/start in RUN; stop wins over start in IDLE.
        drive(0, 0, 0, 1, 1, 8'd20); cyc("r039_ld");
        drive(1, 1, 0, 1, 1, 8'd0); cyc("r039_go");
        drive(0, 1, 1, 1, 1, 8'd9); cyc("r039_all");
        chk("r039_q9", 32'(Q), 9);
        chk("r039_run", 32'(BUSY), 1);
        drive(1, 0, 1, 1, 1, 8'd0); cyc("r039_stop");
        drive(1, 1, 1, 1, 1, 8'd0); cyc("r039_ss");
        chk("r039_idle", 32'(BUSY), 0);

        // Asynchronous clear mid-run at 7.
        drive(0, 0, 0, 0, 0, 8'd7); cyc("r040_load");
        drive(1, 1, 0, 0, 0, 8'd0); cyc("r040_start");
        drive(1, 0, 0, 0, 0, 8'd0);
        #1 CLR_n = 1'b0;
        #1 model_reset();
        check_all("r040_clr");
        chk("r040_q0", 32'(Q), 0);
        chk("r040_busy0", 32'(BUSY), 0);
        #1 CLR_n = 1'b1;
        #1 check_all("r040_rel");
        @(posedge CLK); #1;
        check_all("r040_edge");

`ifdef DOWN_TIMER_PRESCALE_EN
        // Prescaled expiry from 1: pulse 8 edges after the start edge.
        drive(0, 0, 0, 0, 1, 8'd1); cyc("r041_load");
        drive(1, 1, 0, 0, 1, 8'd0); cyc("r041_start");
        drive(1, 0, 0, 0, 1, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            cyc("r041_run");
            chk("r041_tc", 32'(TC_PULSE), 32'(i == 8));
        end
`endif

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, W'($urandom_range(0, 6)));
            if ($urandom_range(0, 199) == 0) begin
                #2 CLR_n = 1'b0;
                #1 model_reset();
                check_all("rnd_clr");
                #1 CLR_n = 1'b1;
            end
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 8, counter and reload width in bits (2..16).
REQ-002 Parameter PRESCALE, default 4, tick divider ratio (2..256); used only when DOWN_TIMER_PRESCALE_EN is defined.
REQ-003 Port CLK  input  1  rising-edge clock.
REQ-004 Port CLR_n  input  1  reset; asynchronous, active-low.
REQ-005 Port D  input  WIDTH  preload value.
REQ-006 Port LOAD_n  input  1  synchronous load strobe, active-low.
REQ-007 Port START  input  1  start request, sampled each CLK edge.
REQ-008 Port STOP  input  1  stop request, sampled each CLK edge.
REQ-009 Port MODE  input  1  0 = one-shot, 1 = auto-reload.
REQ-010 Port ENT  input  1  count enable / cascade enable in.
REQ-011 Port Q  output  WIDTH  current count, registered.
REQ-012 Port BO  output  1  borrow out, combinational: (Q == 0) && ENT.
REQ-013 Port TC_PULSE  output  1  registered one-cycle expiry pulse.
REQ-014 Port BUSY  output  1  high while in state RUN, registered.

Function
REQ-015 Two states: IDLE and RUN; BUSY = (state == RUN).
REQ-016 Per-edge priority: LOAD_n low > STOP > START > counting.
REQ-017 LOAD_n low: Q <= D and RELOAD <= D; state unchanged; TC_PULSE <= 0.
REQ-018 STOP high and LOAD_n high: state <= IDLE; Q holds; TC_PULSE <= 0.
REQ-019 START in IDLE, STOP low, LOAD_n high: state <= RUN; Q holds; no tick that cycle.
REQ-020 START in RUN: ignored.
REQ-021 tick = ENT && RUN without prescaler; with prescaler see REQ-031.
REQ-022 RUN, tick, Q != 0: Q <= Q - 1.
REQ-023 RUN, tick, Q == 0: TC_PULSE <= 1 for exactly one cycle.
REQ-024 Expiry with MODE = 1: Q <= RELOAD; stays in RUN.
REQ-025 Expiry with MODE = 0: state <= IDLE; Q stays 0.
REQ-026 Period from load of N to first TC_PULSE: N+1 ticks; auto-reload period: N+1 ticks.
REQ-027 Start with Q == 0 and ENT high: TC_PULSE on the first tick.
REQ-028 Q never wraps below 0; all arithmetic is modulo-free, WIDTH bits.
REQ-029 ENT low: Q, prescaler and state frozen; START, STOP and LOAD_n still act.
REQ-030 TC_PULSE is 0 in every cycle without an expiry.

Configuration
REQ-031 With DOWN_TIMER_PRESCALE_EN defined: internal prescaler P counts 0..PRESCALE-1 while RUN && ENT; tick = RUN && ENT && (P == PRESCALE-1); P wraps to 0 on a tick.
REQ-032 With the macro defined: P <= 0 on LOAD_n low, on START accepted, on STOP and on reset.
REQ-033 Without the macro: no prescaler logic; tick every RUN && ENT cycle; PRESCALE is ignored.

Reset
REQ-034 CLR_n low immediately forces Q = 0, RELOAD = 0, state = IDLE, TC_PULSE = 0, BUSY = 0 and P = 0, independent of CLK.
REQ-035 Reset asserted mid-RUN aborts the count with no TC_PULSE; deassertion takes effect at the next CLK edge only.

Verification
REQ-036 Load D = 3, MODE = 0, START, ENT = 1, no prescaler -> Q 3,2,1,0; TC_PULSE on the 4th tick; then BUSY = 0, Q = 0.
REQ-037 Load D = 2, MODE = 1 -> Q 2,1,0,2,1,0; TC_PULSE every 3 cycles; BUSY stays 1.
REQ-038 RUN at Q = 5, ENT low for 4 cycles -> Q holds 5, BO = 0; at Q = 0 with ENT = 1 -> BO = 1.
REQ-039 Same-cycle LOAD_n low, STOP and START with D = 9 in RUN -> Q = 9, state RUN, TC_PULSE 0; STOP and START together in IDLE -> stays IDLE.
REQ-040 CLR_n pulsed low between edges during RUN at Q = 7 -> Q = 0 and BUSY = 0 before the next edge; no TC_PULSE.
REQ-041 With the macro and PRESCALE = 4, load D = 1 and START -> Q decrements every 4 cycles; TC_PULSE 8 cycles after START.
